// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared state/owner types and default widths for mem_port_arbiter
package mem_arb_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the arbiter; slave = arbiter view
interface mem_port_arbiter_if import mem_arb_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ready_o;
    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              dm_ready_o;
    logic              stall_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              err_o;
    modport slave (
        input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_ack_i, mem_rdata_i,
        output if_rdata_o, if_ready_o, dm_rdata_o, dm_ready_o, stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
    );
    modport master (
        output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_ack_i, mem_rdata_i,
        input  if_rdata_o, if_ready_o, dm_rdata_o, dm_ready_o, stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
    );
endinterface

// File: rtl/mem_port_arbiter_wdog.sv
// mem_arb_wdog: BUSY-cycle counter flagging a memory timeout at TIMEOUT_CYC-1 (used with MEM_ARB_TIMEOUT_EN)
module mem_arb_wdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic busy_i,
    input  logic ack_i,
    output logic expired_o
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign expired_o = busy_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    always_comb cnt_d = start_i ? '0 : (busy_i && !ack_i && !expired_o) ? cnt_q + CNT_W'(1) : cnt_q;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fixed-priority IF/MEM sharing of one memory port; MEM_ARB_TIMEOUT_EN adds a BUSY timeout with sticky err_o
module mem_port_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input logic               clk_i,
    input logic               rst_i,
    mem_port_arbiter_if.slave bus
);
    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic              if_ready_q, if_ready_d, dm_ready_q, dm_ready_d, err_q, err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic              expired, done;
`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (state_q == IDLE),
        .busy_i   (state_q == BUSY),
        .ack_i    (bus.mem_ack_i),
        .expired_o(expired)
    );
`else
    assign expired = 1'b0;
`endif
    assign done = bus.mem_ack_i | expired;
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        err_d       = err_q | (expired & ~bus.mem_ack_i);
        unique case (state_q)
            IDLE: if (bus.dm_req_i || bus.if_req_i) begin
                state_d     = BUSY;
                owner_d     = bus.dm_req_i ? OWN_DM : OWN_IF;
                mem_req_d   = 1'b1;
                mem_we_d    = bus.dm_req_i & bus.dm_we_i;
                mem_addr_d  = bus.dm_req_i ? bus.dm_addr_i : bus.if_addr_i;
                mem_wdata_d = bus.dm_req_i ? bus.dm_wdata_i : mem_wdata_q;
            end
            BUSY: if (done) begin
                state_d    = RESP;
                mem_req_d  = 1'b0;
                mem_we_d   = 1'b0;
                if_ready_d = owner_q == OWN_IF;
                dm_ready_d = owner_q == OWN_DM;
                // a timeout completes the handshake but leaves the owner's read data untouched
                if (bus.mem_ack_i && !mem_we_q) begin
                    if_rdata_d = (owner_q == OWN_IF) ? bus.mem_rdata_i : if_rdata_q;
                    dm_rdata_d = (owner_q == OWN_DM) ? bus.mem_rdata_i : dm_rdata_q;
                end
            end
            RESP: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            err_q       <= err_d;
        end
    end
    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.dm_rdata_o  = dm_rdata_q;
    assign bus.if_ready_o  = if_ready_q;
    assign bus.dm_ready_o  = dm_ready_q;
    assign bus.err_o       = err_q;
    assign bus.stall_o     = (bus.if_req_i & ~if_ready_q) | (bus.dm_req_i & ~dm_ready_q);
endmodule
